mul24_sched: RTL and testbench
==============================

# mul24_sched

Round-robin scheduler that shares one pipelined 24x24 multiplier (`mul24`) among `NREQ` requesters. It issues at most one multiply per cycle and tracks each in-flight operation with a tag pipeline matched to the multiplier latency. It routes every 48-bit product back to the requester that issued it. It sits between the requesting datapaths and a single `mul24` instance, driving that instance's `num1`/`num2` inputs and consuming its `product` output.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `MUL_LATENCY`, default 2: clock edges from a change on `mul_a`/`mul_b` to the matching `mul_p` being valid (0 = combinational multiplier).
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: bit i high = requester i holds valid operands.
- `a_in` in NREQ*24: operand A, requester i at bits [24i+23:24i].
- `b_in` in NREQ*24: operand B, same packing.
- `gnt` out NREQ: one-hot and combinational; bit i high = requester i's operands are taken at this edge.
- `mul_a` out 24: registered; drives `mul24` `num1`.
- `mul_b` out 24: registered; drives `mul24` `num2`.
- `mul_p` in 48: `mul24` `product`.
- `res_valid` out NREQ: one-hot, registered, single-cycle pulse.
- `res` out 48: registered product; valid only while a `res_valid` bit is high.
- `busy` out 1: high while any tag is in flight or a result is being presented.

## Operation
- Arbitration:
  - Round-robin pointer `ptr`, reset 0.
  - `gnt` selects the first asserted `req` bit at or after `ptr`, wrapping modulo NREQ.
  - When a grant is issued to requester i, `ptr` becomes (i+1) mod NREQ at the same edge. `ptr` is unchanged when no request is pending.
  - `gnt` is zero when `req` is zero. `gnt` never has more than one bit set.
- Issue:
  - At the edge ending a granted cycle, `mul_a`/`mul_b` load that requester's operands.
  - With no grant, they load 0.
  - A tag {valid=1, id=i} enters stage 0 of the tag pipeline.
- Tag pipeline:
  - MUL_LATENCY+1 stages of {valid, id}, shifted every cycle. There is no stall, because `mul24` has no backpressure.
  - When the last stage is valid, `res` loads `mul_p` and `res_valid[id]` pulses for one cycle.
- Requester rules:
  - A requester keeps `req`, `a_in` and `b_in` stable until it sees `gnt`.
  - It may keep `req` high to issue again in the next cycle.
  - Results cannot be refused.
- Arithmetic: unsigned, full 48-bit product, no truncation or saturation.
- Reset:
  - On `rst_n` low, asynchronously clear `ptr`, `mul_a`, `mul_b`, all tag valids, `res` (0), `res_valid` (0) and `busy` (0).
  - In-flight operations are dropped silently; their results never pulse.

## Timing
- Grant in cycle T, operands on `mul_a`/`mul_b` in T+1, `res_valid`/`res` in cycle T+2+MUL_LATENCY. With the default this is T+4.
- Throughput is one issue per cycle. Results return in issue order, one per cycle at most.
- With N requesters continuously requesting, each is granted exactly once every N cycles.
- A requester that drops `req` in the same cycle as its grant still completes.
- Raising `req` in cycle T can be granted in cycle T (combinational path from `req` to `gnt`).
- `busy` is registered: high from T+1 after any grant until the cycle after the last `res_valid` pulse.

## Structure
- Shared package `mul24_pkg`:
  - `OP_W` = 24 and `PROD_W` = 48.
  - Default `NREQ` and `MUL_LATENCY`.
  - The tag struct {valid, id[$clog2(NREQ)-1:0]}.
- Sub-module `rr_arbiter` (parameter `NREQ`): `req` and `ptr` in, one-hot `gnt` and next `ptr` out.
  - The pointer register lives in `rr_arbiter`.
  - The tag pipeline and result register live in `mul24_sched`.
- `mul24` is instantiated by the parent, not inside this block. The bench instantiates it alongside.

## Test plan
- Single request:
  - Stimulus: requester 0 only, a=7, b=15.
  - Response: `gnt`=0001 in cycle T; `res_valid`=0001 with `res`=105 in T+4; `busy` low again in T+5.
- Simultaneous requests:
  - Stimulus: all four requesters raise `req` together with (7,15), (324,31), (3,3), (16777215,16777215).
  - Response: grants 0,1,2,3 on consecutive cycles; results 105, 10044, 9, 281474943156225 on consecutive cycles, each with the correct `res_valid` bit.
- Back-to-back single requester:
  - Stimulus: requester 2 holds `req` for 3 cycles, changing operands after each grant to (1,1), (2,2), (0,5).
  - Response: three `res_valid`=0100 pulses on consecutive cycles with `res` = 1, 4, 0.
- Fairness:
  - Stimulus: requesters 1 and 3 hold `req` continuously for 10 cycles.
  - Response: grants alternate 1,3,1,3…; each requester receives 5 grants.
- Reset mid-flight:
  - Stimulus: grant two operations, then pulse `rst_n` low asynchronously, between edges, at T+2.
  - Response: all outputs go to 0 immediately; no `res_valid` ever pulses for the dropped operations; the next request after reset is granted from pointer 0.
- Pointer wrap:
  - Stimulus: grant requester 3; next cycle requesters 0 and 2 request.
  - Response: requester 0 is granted first, because `ptr` wrapped to 0.

Source files
------------

// File: rtl/mul24_pkg.sv
// Shared definitions for the shared 24x24 multiplier scheduler.
package mul24_pkg;

    localparam int OP_W            = 24;
    localparam int PROD_W          = 48;
    localparam int NREQ_DEF        = 4;
    localparam int MUL_LATENCY_DEF = 2;

    // The tag id is sized for the largest supported requester count (8),
    // so one struct type serves every NREQ from 2 to 8.
    localparam int NREQ_MAX        = 8;
    localparam int TAG_ID_W        = $clog2(NREQ_MAX);

    // One in-flight multiply: valid flag plus the id of the issuing requester.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul24_sched_if.sv
// Requester and multiplier-side bus of the multiplier scheduler.
interface mul24_sched_if
    import mul24_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) ();

    logic [NREQ-1:0]      req;
    logic [NREQ*OP_W-1:0] a_in;
    logic [NREQ*OP_W-1:0] b_in;
    logic [NREQ-1:0]      gnt;
    logic [OP_W-1:0]      mul_a;
    logic [OP_W-1:0]      mul_b;
    logic [PROD_W-1:0]    mul_p;
    logic [NREQ-1:0]      res_valid;
    logic [PROD_W-1:0]    res;
    logic                 busy;

    // Scheduler side.
    modport slave (
        input  req, a_in, b_in, mul_p,
        output gnt, mul_a, mul_b, res_valid, res, busy
    );

    // Requesters plus the multiplier, seen from outside the scheduler.
    modport master (
        output req, a_in, b_in, mul_p,
        input  gnt, mul_a, mul_b, res_valid, res, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer held here.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  i_req,
    output logic [NREQ-1:0]  o_gnt,
    output logic [PTR_W-1:0] o_gnt_id,
    output logic [PTR_W-1:0] o_ptr_nxt
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_gnt_id;
    logic [NREQ-1:0]  w_gnt;
    logic             w_found;

    // Pick the first requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_gnt     = '0;
        w_gnt_id  = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        for (int off = 0; off < NREQ; off++) begin
            int idx;
            idx = (int'(r_ptr) + off) % NREQ;
            if (!w_found && i_req[idx]) begin
                w_gnt[idx] = 1'b1;
                w_gnt_id   = PTR_W'(idx);
                w_ptr_nxt  = PTR_W'((idx + 1) % NREQ);
                w_found    = 1'b1;
            end else begin
                w_found    = w_found;
            end
        end
    end

    // Pointer advances past the winner; it holds when nobody requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_gnt     = w_gnt;
    assign o_gnt_id  = w_gnt_id;
    assign o_ptr_nxt = w_ptr_nxt;

endmodule

// File: rtl/mul24_sched.sv
// Shares one pipelined 24x24 multiplier among NREQ requesters and routes
// each product back to its issuer through a tag pipeline.
module mul24_sched
    import mul24_pkg::*;
#(
    parameter  int NREQ        = NREQ_DEF,
    parameter  int MUL_LATENCY = MUL_LATENCY_DEF,
    localparam int PTR_W       = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    mul24_sched_if.slave  bus
);

    logic [NREQ-1:0]   w_gnt;
    logic [PTR_W-1:0]  w_gnt_id;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic              w_gnt_any;
    logic [OP_W-1:0]   w_sel_a;
    logic [OP_W-1:0]   w_sel_b;
    tag_t              w_tag_in;
    logic              w_busy_nxt;

    logic [OP_W-1:0]   r_mul_a;
    logic [OP_W-1:0]   r_mul_b;
    tag_t              r_tags [MUL_LATENCY+1];
    logic [PROD_W-1:0] r_res;
    logic [NREQ-1:0]   r_res_valid;
    logic              r_busy;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req),
        .o_gnt     (w_gnt),
        .o_gnt_id  (w_gnt_id),
        .o_ptr_nxt (w_ptr_nxt)
    );

    assign w_gnt_any = |w_gnt;

    // Operand mux driven by the one-hot grant; zero when nothing is granted.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = bus.a_in[i*OP_W +: OP_W];
                w_sel_b = bus.b_in[i*OP_W +: OP_W];
            end else begin
                w_sel_a = w_sel_a;
                w_sel_b = w_sel_b;
            end
        end
    end

    // New tag for this cycle and the next value of busy: any issue, any
    // tag still travelling, or a last-stage tag about to become a result.
    always_comb begin
        w_tag_in.valid = w_gnt_any;
        w_tag_in.id    = TAG_ID_W'(w_gnt_id);
        w_busy_nxt     = w_gnt_any;
        for (int k = 0; k <= MUL_LATENCY; k++) begin
            w_busy_nxt = w_busy_nxt | r_tags[k].valid;
        end
    end

    // Issue registers, tag shift pipeline and result register. Reset drops
    // every in-flight tag so those products never surface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            for (int k = 0; k <= MUL_LATENCY; k++) begin
                r_tags[k] <= '0;
            end
            r_res       <= '0;
            r_res_valid <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_mul_a   <= w_sel_a;
            r_mul_b   <= w_sel_b;
            r_tags[0] <= w_tag_in;
            for (int k = 1; k <= MUL_LATENCY; k++) begin
                r_tags[k] <= r_tags[k-1];
            end
            if (r_tags[MUL_LATENCY].valid) begin
                r_res <= bus.mul_p;
            end else begin
                r_res <= r_res;
            end
            for (int i = 0; i < NREQ; i++) begin
                r_res_valid[i] <= r_tags[MUL_LATENCY].valid &&
                                  (r_tags[MUL_LATENCY].id == TAG_ID_W'(i));
            end
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.res       = r_res;
    assign bus.res_valid = r_res_valid;
    assign bus.busy      = r_busy;

    // The arbiter holds its own pointer; its look-ahead is only for observers.
    logic w_unused_ptr;
    assign w_unused_ptr = ^w_ptr_nxt;

endmodule

// File: tb/tb_mul24_sched.sv
// Bench for mul24_sched: scenario tasks plus a scoreboard of expected results.
module tb_mul24_sched;
    import mul24_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    mul24_sched_if #(.NREQ(NREQ)) bus ();

    mul24_sched #(
        .NREQ        (NREQ),
        .MUL_LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in for the external mul24: two register stages.
    logic [47:0] r_p1, r_p2;
    always @(posedge clk) begin
        r_p1 <= {24'd0, bus.mul_a} * {24'd0, bus.mul_b};
        r_p2 <= r_p1;
    end
    assign bus.mul_p = r_p2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [47:0] prod;
        int          due;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              mon_id;
    logic [NREQ-1:0] mon_vec;

    // Scoreboard: push on each grant, pop and compare on each result pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL result_missing: id %0d due in cycle %0d, nothing by cycle %0d",
                         sb[0].id, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (bus.res_valid != '0) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_spurious: res_valid=%b res=%0d, expected no result",
                             bus.res_valid, bus.res);
                end else begin
                    mon_e   = sb.pop_front();
                    mon_vec = '0;
                    mon_vec[mon_e.id] = 1'b1;
                    if (bus.res_valid !== mon_vec || bus.res !== mon_e.prod || cyc != mon_e.due) begin
                        n_fail++;
                        $display("FAIL result: got res_valid=%b res=%0d cycle %0d, expected res_valid=%b res=%0d cycle %0d",
                                 bus.res_valid, bus.res, cyc, mon_vec, mon_e.prod, mon_e.due);
                    end
                end
            end
            if (bus.gnt != '0) begin
                mon_id = 0;
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (bus.gnt[i]) mon_id = i;
                end
                mon_e.id   = mon_id;
                mon_e.prod = {24'd0, bus.a_in[mon_id*24 +: 24]} * {24'd0, bus.b_in[mon_id*24 +: 24]};
                mon_e.due  = cyc + 2 + LAT;
                sb.push_back(mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [23:0] a, input logic [23:0] b);
        bus.a_in[i*24 +: 24] = a;
        bus.b_in[i*24 +: 24] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        rst_n    = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0000 || bus.res_valid !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt=%b res_valid=%b busy=%b, expected 0/0/0",
                     bus.gnt, bus.res_valid, bus.busy);
        end
        n_cmp++;
        if (bus.mul_a !== 24'd0 || bus.mul_b !== 24'd0 || bus.res !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_data: mul_a=%0d mul_b=%0d res=%0d, expected 0/0/0",
                     bus.mul_a, bus.mul_b, bus.res);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_op(0, 24'd7, 24'd15);
        bus.req = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_gnt: gnt=%b, expected 0001", bus.gnt);
        end
        tick();
        bus.req = 4'b0000;
        for (int d = 1; d <= 5; d++) begin
            @(negedge clk);
            if (d == 1) begin
                n_cmp++;
                if (bus.mul_a !== 24'd7 || bus.mul_b !== 24'd15) begin
                    n_fail++;
                    $display("FAIL single_issue: mul_a=%0d mul_b=%0d, expected 7/15", bus.mul_a, bus.mul_b);
                end
            end
            if (d == 4) begin
                n_cmp++;
                if (bus.res_valid !== 4'b0001 || bus.res !== 48'd105) begin
                    n_fail++;
                    $display("FAIL single_res: res_valid=%b res=%0d, expected 0001/105", bus.res_valid, bus.res);
                end
            end
            n_cmp++;
            if (bus.busy !== (d <= 4)) begin
                n_fail++;
                $display("FAIL single_busy: T+%0d busy=%b, expected %0d", d, bus.busy, (d <= 4));
            end
            tick();
        end
        drain();
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_g;
        set_op(0, 24'd7, 24'd15);
        set_op(1, 24'd324, 24'd31);
        set_op(2, 24'd3, 24'd3);
        set_op(3, 24'hFFFFFF, 24'hFFFFFF);
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_g = '0;
            exp_g[k] = 1'b1;
            n_cmp++;
            if (bus.gnt !== exp_g) begin
                n_fail++;
                $display("FAIL simul_gnt: step %0d gnt=%b, expected %b", k, bus.gnt, exp_g);
            end
            tick();
            bus.req[k] = 1'b0;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [23:0] va [3];
        logic [47:0] got [$];
        int          got_cyc [$];
        va[0] = 24'd1; va[1] = 24'd2; va[2] = 24'd0;
        bus.req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            set_op(2, va[k], (k == 2) ? 24'd5 : va[k]);
            @(negedge clk);
            n_cmp++;
            if (bus.gnt !== 4'b0100) begin
                n_fail++;
                $display("FAIL b2b_gnt: step %0d gnt=%b, expected 0100", k, bus.gnt);
            end
            tick();
        end
        bus.req = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.res_valid == 4'b0100) begin
                got.push_back(bus.res);
                got_cyc.push_back(cyc);
            end
            tick();
        end
        n_cmp++;
        if (got.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: %0d pulses, expected 3", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== 48'd1 || got[1] !== 48'd4 || got[2] !== 48'd0 ||
                got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
                n_fail++;
                $display("FAIL b2b_res: got %0d,%0d,%0d at %0d,%0d,%0d, expected 1,4,0 consecutive",
                         got[0], got[1], got[2], got_cyc[0], got_cyc[1], got_cyc[2]);
            end
        end
        drain();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        int         n1, n3;
        n1 = 0;
        n3 = 0;
        do_reset();
        set_op(1, 24'($urandom()), 24'($urandom()));
        set_op(3, 24'($urandom()), 24'($urandom()));
        bus.req = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            n_cmp++;
            if (bus.gnt !== exp_g) begin
                n_fail++;
                $display("FAIL fair_gnt: step %0d gnt=%b, expected %b", k, bus.gnt, exp_g);
            end
            if (bus.gnt[1]) n1++;
            if (bus.gnt[3]) n3++;
            tick();
            if (k % 2 == 0) set_op(1, 24'($urandom()), 24'($urandom()));
            else            set_op(3, 24'($urandom()), 24'($urandom()));
        end
        bus.req = 4'b0000;
        n_cmp++;
        if (n1 != 5 || n3 != 5) begin
            n_fail++;
            $display("FAIL fair_count: grants r1=%0d r3=%0d, expected 5/5", n1, n3);
        end
        drain();
    endtask

    task automatic test_ptr_wrap();
        set_op(3, 24'd1000, 24'd3);
        set_op(0, 24'd11, 24'd13);
        set_op(2, 24'd17, 24'd19);
        bus.req = 4'b1000;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_gnt3: gnt=%b, expected 1000", bus.gnt);
        end
        tick();
        bus.req = 4'b0101;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_gnt0: gnt=%b, expected 0001", bus.gnt);
        end
        tick();
        bus.req = 4'b0100;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_gnt2: gnt=%b, expected 0100", bus.gnt);
        end
        tick();
        bus.req = 4'b0000;
        drain();
    endtask

    task automatic test_reset_midflight();
        int pulses, busy_hi;
        pulses  = 0;
        busy_hi = 0;
        set_op(1, 24'd123, 24'd456);
        set_op(2, 24'd789, 24'd10);
        bus.req = 4'b0110;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_pre_gnt1: gnt=%b, expected 0010", bus.gnt);
        end
        tick();
        bus.req = 4'b0100;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL rst_pre_gnt2: gnt=%b, expected 0100", bus.gnt);
        end
        tick();
        bus.req = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.mul_a !== 24'd0 || bus.mul_b !== 24'd0 || bus.res !== 48'd0 ||
            bus.res_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async: mul_a=%0d mul_b=%0d res=%0d res_valid=%b busy=%b gnt=%b, expected all 0",
                     bus.mul_a, bus.mul_b, bus.res, bus.res_valid, bus.busy, bus.gnt);
        end
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.res_valid != 4'b0000) pulses++;
            if (bus.busy != 1'b0) busy_hi++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (pulses != 0 || busy_hi != 0) begin
            n_fail++;
            $display("FAIL rst_dropped: %0d result pulses, %0d busy cycles, expected 0/0", pulses, busy_hi);
        end
        set_op(0, 24'd9, 24'd9);
        set_op(3, 24'd8, 24'd8);
        bus.req = 4'b1001;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_ptr: gnt=%b, expected 0001", bus.gnt);
        end
        tick();
        bus.req = 4'b1000;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_next: gnt=%b, expected 1000", bus.gnt);
        end
        tick();
        bus.req = 4'b0000;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_simultaneous();
        test_back_to_back();
        test_fairness();
        test_ptr_wrap();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, expected completion within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
